// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and default
// data-memory timeout.
package pipe_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pipeline_sequencer.sv
// Pipeline control: freeze on data-memory wait, stall on load-use/branch hazards,
// flush on taken control flow. Optional counters under PIPE_SEQ_PERF_EN.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idBranch,
  input  logic             idJump,
  input  logic             idTaken,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [4:0]       exRd,
  input  logic             memMemRead,
  input  logic [4:0]       memRd,
  input  logic             dmemReq,
  input  logic             dmemReady,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             exmemWrite,
`ifdef PIPE_SEQ_PERF_EN
  input  logic             perfClr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount,
  output logic [CNT_W-1:0] memWaitCycles,
`endif
  output logic             memTimeout
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] TimeoutCnt = WaitW'(MEM_TIMEOUT);

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;

  logic ex_src_match, mem_src_match;
  logic load_use, branch_haz, freeze;

  assign ex_src_match  = (exRd != 5'd0) &&
                         ((idUsesRs && (exRd == idRs)) || (idUsesRt && (exRd == idRt)));
  assign mem_src_match = (memRd != 5'd0) &&
                         ((idUsesRs && (memRd == idRs)) || (idUsesRt && (memRd == idRt)));

  assign load_use   = exMemRead && ex_src_match;
  // A branch compares in ID, so it must also wait out an ALU result in EX and a load in MEM.
  assign branch_haz = idBranch && ((exRegWrite && ex_src_match) ||
                                   (memMemRead && mem_src_match));

  assign freeze = (state_q == StRun) ? (dmemReq && !dmemReady) : !dmemReady;

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    exmemWrite = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    if (freeze) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      exmemWrite = 1'b0;
    end else if (load_use || branch_haz) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end else if (idJump || (idBranch && idTaken)) begin
      ifidFlush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      memTimeout <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          wait_cnt_q <= '0;
          if (dmemReq && !dmemReady) state_q <= StMemWait;
        end
        StMemWait: begin
          if (wait_cnt_q != TimeoutCnt) wait_cnt_q <= wait_cnt_q + WaitW'(1);
          if (wait_cnt_q == TimeoutCnt - WaitW'(1)) memTimeout <= 1'b1;
          if (dmemReady) state_q <= StRun;
        end
      endcase
    end
  end

`ifdef PIPE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles   <= '0;
      flushCount    <= '0;
      memWaitCycles <= '0;
    end else if (perfClr) begin
      stallCycles   <= '0;
      flushCount    <= '0;
      memWaitCycles <= '0;
    end else begin
      if (idexBubble && !(&stallCycles))  stallCycles   <= stallCycles + CNT_W'(1);
      if (ifidFlush && !(&flushCount))    flushCount    <= flushCount + CNT_W'(1);
      if (freeze && !(&memWaitCycles))    memWaitCycles <= memWaitCycles + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes the optional counters.
  if (CNT_W == 0) begin : g_no_counters
  end
`endif

endmodule
